// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock, non-reset signal of the instruction fetch stage.
//   redirect_valid / redirect_pc   : PC redirect from the branch unit
//   imem_req_valid/ready/addr      : word fetch request to instruction memory
//   imem_rsp_valid / imem_rsp_data : 1-cycle response pulse from memory
//   inst_valid/ready/data/pc       : fetch queue head presented to decode
//   misalign_err                   : pulse when a redirect target is unaligned
// Modports:
//   master : the fetch unit itself
//   slave  : the surroundings (branch unit, memory, decode)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_data, inst_pc,
        output misalign_err
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_data, inst_pc,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of the RV32 core. Owns the architectural fetch PC,
// issues one word fetch at a time to instruction memory, buffers returned
// instructions in a small {pc,inst} queue for decode, and restarts at the
// branch target on a redirect, discarding wrong-path work.
// Parameters:
//   RESET_PC : fetch PC loaded on reset
//   DEPTH    : fetch queue entries (power of 2, >= 2)
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : fetch_unit_if.master (redirect, imem request/response, decode side)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // REQ: may issue a request. WAIT: a good request is in flight.
    // DRAIN: an in-flight request became wrong-path; its response is dropped.
    typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic             misalign_q;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             handshake;
    logic             push;
    logic             pop;

    // A request goes out only when a queue slot is guaranteed free for its
    // response, so a push can never overflow. Reset gates it so nothing is
    // requested while rst is held.
    assign bus.imem_req_valid = !rst && (state == REQ) && (count < FULL);
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_data      = inst_mem[rd_ptr];
    assign bus.inst_pc        = pc_mem[rd_ptr];
    assign bus.misalign_err   = misalign_q;

    // A redirect voids both the push of a returning response and any pop
    // decode attempts in the same cycle.
    assign handshake = bus.imem_req_valid && bus.imem_req_ready;
    assign push      = !bus.redirect_valid && (state == WAIT) && bus.imem_rsp_valid;
    assign pop       = !bus.redirect_valid && bus.inst_valid && bus.inst_ready;

    // Fetch control FSM: owns fetch_pc and the misalign pulse. A redirect
    // always wins; if a request is still in flight the FSM goes to DRAIN so
    // the stale response is swallowed, otherwise straight back to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REQ;
            fetch_pc   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (bus.redirect_valid) begin
                fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
                misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
                case (state)
                    REQ:     state <= handshake ? DRAIN : REQ;
                    WAIT:    state <= bus.imem_rsp_valid ? REQ : DRAIN;
                    DRAIN:   state <= bus.imem_rsp_valid ? REQ : DRAIN;
                    default: state <= REQ;
                endcase
            end else begin
                case (state)
                    REQ: begin
                        if (handshake) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rsp_valid) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (bus.imem_rsp_valid) begin
                            state <= REQ;
                        end
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end

    // Fetch queue: circular buffer of {pc,inst}. The head is read straight
    // out of storage, which is cleared on reset so inst_data/inst_pc start
    // at zero. A redirect flushes by rewinding both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= fetch_pc;
                inst_mem[wr_ptr] <= bus.imem_rsp_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit with directed sequences followed by random traffic and
// compares every cycle against a transaction-level reference: a queue of the
// {pc,inst} pairs decode should see, the address the next request must carry,
// and whether a fetch is outstanding.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    entry_t      model_q[$];
    logic        dut_busy;
    logic        stale;
    logic [31:0] next_addr;
    logic [31:0] req_addr;
    logic        exp_misalign;

    // Memory responder state
    logic        mem_pending;
    logic [31:0] mem_addr;

    int checks = 0;
    int errors = 0;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the DUT against the reference for the current cycle.
    task automatic checkOutput();
        logic exp_valid;
        exp_valid = !dut_busy && (model_q.size() < DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_valid);
        if (!dut_busy) chk("req_addr", bus.imem_req_addr, next_addr);
        chk("inst_valid", bus.inst_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            chk("inst_pc", bus.inst_pc, model_q[0].pc);
            chk("inst_data", bus.inst_data, model_q[0].data);
        end
        chk("misalign", bus.misalign_err, exp_misalign);
    endtask

    // Advance the reference by the events that happen at the coming edge.
    task automatic model_update();
        logic   hs;
        logic   rsp;
        logic   redir;
        int     size0;
        entry_t e;
        hs    = !dut_busy && (model_q.size() < DEPTH) && bus.imem_req_ready;
        rsp   = bus.imem_rsp_valid;
        redir = bus.redirect_valid;
        size0 = model_q.size();
        exp_misalign = redir && (bus.redirect_pc[1:0] != 2'b00);
        if (!redir && size0 != 0 && bus.inst_ready) void'(model_q.pop_front());
        if (rsp) begin
            mem_pending = 1'b0;
            if (dut_busy && !stale && !redir) begin
                e.pc   = req_addr;
                e.data = mem_word(req_addr);
                model_q.push_back(e);
            end
            dut_busy = 1'b0;
        end
        if (hs) begin
            dut_busy    = 1'b1;
            stale       = 1'b0;
            req_addr    = next_addr;
            next_addr   = next_addr + 32'd4;
            mem_pending = 1'b1;
            mem_addr    = bus.imem_req_addr;
        end
        if (redir) begin
            model_q.delete();
            next_addr = {bus.redirect_pc[31:2], 2'b00};
            stale     = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check and update
    // the reference on the falling edge, then move to the next edge.
    task automatic applyStimulus(input logic rdy, input logic irdy, input logic redir,
                                 input logic [31:0] rpc, input logic rsp_en);
        bus.imem_req_ready = rdy;
        bus.inst_ready     = irdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = mem_pending && rsp_en;
        bus.imem_rsp_data  = mem_pending ? mem_word(mem_addr) : $urandom;
        @(negedge clk);
        checkOutput();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic immediate);
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        rst = 1'b1;
        #1;
        if (immediate) begin
            chk("rst_req_valid", bus.imem_req_valid, 1'b0);
            chk("rst_inst_valid", bus.inst_valid, 1'b0);
            chk("rst_misalign", bus.misalign_err, 1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid_held", bus.imem_req_valid, 1'b0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_addr", bus.imem_req_addr, RESET_PC);
        rst = 1'b0;
        model_q.delete();
        dut_busy     = 1'b0;
        stale        = 1'b0;
        next_addr    = RESET_PC;
        req_addr     = RESET_PC;
        exp_misalign = 1'b0;
    endtask

    initial begin
        mem_pending = 1'b0;
        mem_addr    = '0;

        // Power-on reset
        reset_dut(1'b0);

        // Streaming with 1-cycle response latency
        $display("[TB] streaming fetch");
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Decode stalled: queue fills and fetch stops at 8
        $display("[TB] decode backpressure");
        reset_dut(1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_req_valid", bus.imem_req_valid, 1'b0);
        chk("stall_addr", bus.imem_req_addr, 32'h8);
        chk("stall_head_pc", bus.inst_pc, 32'h0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect while waiting, late response is drained
        $display("[TB] redirect in WAIT");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("drain_empty", bus.inst_valid, 1'b0);
        chk("drain_addr", bus.imem_req_addr, 32'h100);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect coinciding with a response, queue occupied
        $display("[TB] redirect with response");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
        chk("redir_rsp_empty", bus.inst_valid, 1'b0);
        chk("redir_rsp_addr", bus.imem_req_addr, 32'h200);
        chk("redir_rsp_req", bus.imem_req_valid, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect target
        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b1);
        chk("misalign_pulse", bus.misalign_err, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("misalign_clear", bus.misalign_err, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space
        $display("[TB] pc wrap");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_req_addr, 32'h0);

        // Reset mid-WAIT; the orphan response afterwards must be ignored
        $display("[TB] reset mid-WAIT");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        reset_dut(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("orphan_ignored", bus.inst_valid, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic
        $display("[TB] random traffic");
        reset_dut(1'b0);
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom,
                          $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
